// File: rtl/control_booth.sv
// Sequencer for a radix-2 Booth multiplier: it drives the A/Q/M register load,
// add/subtract and shift strobes, and signals completion with a start/done handshake.
module control_booth #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] q_bits,
  output logic       carga_m,
  output logic       carga_q,
  output logic       carga_a,
  output logic       sel_cero,
  output logic       clr_q1,
  output logic       resta,
  output logic       desplaza,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | waiting for start, all strobes low
  // LOAD  | load M and Q, clear A and q_-1, arm the iteration counter
  // OP    | add or subtract M into A according to {Q[0], q_-1}
  // SHIFT | arithmetic right shift of A:Q:q_-1, one iteration consumed
  // DONE  | one-cycle completion pulse, product valid in A:Q
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    OP    = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CW = $clog2(N + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Only decremented in SHIFT, where it is at least 1, so it cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state == LOAD) begin
      count <= CW'(N);
    end else if (state == SHIFT) begin
      count <= count - CW'(1);
    end
  end

  always_comb begin
    state_nxt = IDLE;
    carga_m   = 1'b0;
    carga_q   = 1'b0;
    carga_a   = 1'b0;
    sel_cero  = 1'b0;
    clr_q1    = 1'b0;
    resta     = 1'b0;
    desplaza  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        carga_m   = 1'b1;
        carga_q   = 1'b1;
        carga_a   = 1'b1;
        sel_cero  = 1'b1;
        clr_q1    = 1'b1;
        busy      = 1'b1;
        state_nxt = OP;
      end
      OP: begin
        busy = 1'b1;
        case (q_bits)
          2'b01: carga_a = 1'b1;
          2'b10: begin
            carga_a = 1'b1;
            resta   = 1'b1;
          end
          default: ;
        endcase
        state_nxt = SHIFT;
      end
      SHIFT: begin
        desplaza  = 1'b1;
        busy      = 1'b1;
        state_nxt = (count == CW'(1)) ? DONE : OP;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_booth.sv
// Bench for control_booth: an offset-based timeline model checks every strobe each cycle,
// and a registered A/Q/M datapath closes the loop to check real products.
module tb_control_booth;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] q_bits;
  logic       carga_m, carga_q, carga_a, sel_cero, clr_q1, resta, desplaza, busy, done;

  logic [1:0]   q_drv;
  logic         use_dp;
  logic [N-1:0] mop, qop;
  logic [N:0]   da;       // carries a guard bit so A-M with M = -2^(N-1) keeps its sign
  logic [N-1:0] dq, dm;
  logic         dq1;

  int vectors;
  int errors;
  int d;                  // cycles since the accepting start edge, 0 when idle

  logic [8:0] outs;
  assign outs   = {carga_m, carga_q, carga_a, sel_cero, clr_q1, resta, desplaza, busy, done};
  assign q_bits = use_dp ? {dq[0], dq1} : q_drv;

  control_booth #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .q_bits(q_bits),
    .carga_m(carga_m), .carga_q(carga_q), .carga_a(carga_a), .sel_cero(sel_cero),
    .clr_q1(clr_q1), .resta(resta), .desplaza(desplaza), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      da  <= '0;
      dq  <= '0;
      dq1 <= 1'b0;
      dm  <= '0;
    end else begin
      if (carga_m) dm <= mop;
      if (carga_q) dq <= qop;
      if (clr_q1) dq1 <= 1'b0;
      if (carga_a) da <= sel_cero ? '0 : (resta ? da - {dm[N-1], dm} : da + {dm[N-1], dm});
      if (desplaza) {da, dq, dq1} <= {da[N], da, dq};
    end
  end

  // Expected strobes from the position within an operation:
  // 1 = LOAD, even 2..2N = OP, odd 3..2N+1 = SHIFT, 2N+2 = DONE.
  function automatic logic [8:0] model_out(int dd, logic [1:0] qb);
    logic [8:0] v;
    v = '0;
    if (dd == 1) begin
      v = 9'b111110010;
    end else if (dd >= 2 && dd <= 2*N+1) begin
      v[1] = 1'b1;
      if (dd % 2 == 0) begin
        v[6] = (qb == 2'b01) || (qb == 2'b10);
        v[3] = (qb == 2'b10);
      end else begin
        v[2] = 1'b1;
      end
    end else if (dd == 2*N+2) begin
      v[0] = 1'b1;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) d = 0;
    else if (d == 0) d = start ? 1 : 0;
    else if (d == 2*N+2) d = 0;
    else d = d + 1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (outs !== 9'b0) begin
      errors++;
      $display("FAIL reset_async got %b want %b", outs, 9'b0);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (outs !== 9'b0) begin
        errors++;
        $display("FAIL idle_quiet cyc %0d got %b want %b", c, outs, 9'b0);
      end
      tick();
    end
  endtask

  task automatic test_pattern(input logic [1:0] qb);
    int n_sh, n_ca, n_busy;
    n_sh = 0; n_ca = 0; n_busy = 0;
    q_drv = qb;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      vectors++;
      if (outs !== model_out(c, qb) || d != c % 11) begin
        errors++;
        $display("FAIL pattern_%b cyc %0d got %b want %b", qb, c, outs, model_out(c, qb));
      end
      if (desplaza) n_sh++;
      if (carga_a && c > 1) n_ca++;
      if (busy) n_busy++;
      tick();
    end
    vectors++;
    if (n_sh != N || n_ca != (((qb == 2'b01) || (qb == 2'b10)) ? N : 0) || n_busy != 2*N+1) begin
      errors++;
      $display("FAIL pulse_count_%b got shifts %0d adds %0d busy %0d", qb, n_sh, n_ca, n_busy);
    end
  endtask

  task automatic test_retrigger();
    q_drv = 2'b10;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      start = (c == 5);
      @(negedge clk);
      vectors++;
      if (outs !== model_out(c, q_drv) || (c == 10 && done !== 1'b1)) begin
        errors++;
        $display("FAIL retrigger cyc %0d got %b want %b", c, outs, model_out(c, q_drv));
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    q_drv = 2'b01;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      vectors++;
      if (outs !== model_out(d, q_drv) || (c == 12 && carga_m !== 1'b1) ||
          (c == 21 && done !== 1'b1) || (c == 11 && outs !== 9'b0)) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b want %b", c, outs, model_out(d, q_drv));
      end
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 12 && d != 0; i++) tick();
  endtask

  task automatic test_reset_mid();
    q_drv = 2'b01;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (d != 7) tick();
    #3;
    reset = 1'b1;
    d = 0;
    #1;
    vectors++;
    if (outs !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_async got %b want %b", outs, 9'b0);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (outs !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_hold got %b want %b", outs, 9'b0);
    end
    tick();
    reset = 1'b0;
    tick();
    test_pattern(2'b01);
  endtask

  task automatic test_closed_loop(input logic [N-1:0] mval, input logic [N-1:0] qval);
    logic [2*N-1:0] expect_p;
    logic [2*N-1:0] prod;
    bit got_done;
    expect_p = $signed(mval) * $signed(qval);
    got_done = 0;
    use_dp = 1'b1;
    mop = mval;
    qop = qval;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 2*N+6 && !got_done; c++) begin
      @(negedge clk);
      vectors++;
      if (outs !== model_out(d, q_bits)) begin
        errors++;
        $display("FAIL loop_strobes cyc %0d got %b want %b", c, outs, model_out(d, q_bits));
      end
      if (done === 1'b1) begin
        got_done = 1;
        prod = {da[N-1:0], dq};
        vectors++;
        if (prod !== expect_p || c != 2*N+2) begin
          errors++;
          $display("FAIL product m=%h q=%h got %h at cyc %0d want %h at cyc %0d",
                   mval, qval, prod, c, expect_p, 2*N+2);
        end
      end
      tick();
    end
    if (!got_done) begin
      errors++;
      $display("FAIL loop_timeout m=%h q=%h got no done want done at cyc %0d", mval, qval, 2*N+2);
    end
    use_dp = 1'b0;
    for (int i = 0; i < 12 && d != 0; i++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      q_drv = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      vectors++;
      if (outs !== model_out(d, q_drv)) begin
        errors++;
        $display("FAIL random cyc %0d pos %0d got %b want %b", c, d, outs, model_out(d, q_drv));
      end
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 12 && d != 0; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    errors  = 0;
    d       = 0;
    reset   = 1'b1;
    start   = 1'b0;
    q_drv   = 2'b00;
    use_dp  = 1'b0;
    mop     = '0;
    qop     = '0;
    test_reset();
    test_pattern(2'b01);
    test_pattern(2'b10);
    test_pattern(2'b00);
    test_pattern(2'b11);
    test_retrigger();
    test_back_to_back();
    test_closed_loop(4'h3, 4'hE);
    test_closed_loop(4'h8, 4'h8);
    for (int i = 0; i < 8; i++) begin
      test_closed_loop(N'($urandom), N'($urandom));
    end
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
